// File: rtl/pc_fetch_ctrl_if.sv
// ============================================================================
//  Module   : pc_fetch_ctrl_if
//  Brief    : Bus between the PC fetch controller and the core datapath.
//             The misaligned flag exists only when PC_ALIGN_CHECK_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_fetch_ctrl_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 en;
    logic                 PCsrc;
    logic [WIDTH-1:0]     ImmOp;
    logic                 restart;
    logic [WIDTH-1:0]     PC;
    logic                 pc_valid;
    logic                 halted;
    logic [CNT_WIDTH-1:0] retired;
`ifdef PC_ALIGN_CHECK_EN
    logic                 misaligned;

    modport master (
        input  en, PCsrc, ImmOp, restart,
        output PC, pc_valid, halted, retired, misaligned
    );
    modport slave (
        output en, PCsrc, ImmOp, restart,
        input  PC, pc_valid, halted, retired, misaligned
    );
`else
    modport master (
        input  en, PCsrc, ImmOp, restart,
        output PC, pc_valid, halted, retired
    );
    modport slave (
        output en, PCsrc, ImmOp, restart,
        input  PC, pc_valid, halted, retired
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Brief    : Program-counter stage with boot cycle, stall, branch-to-self halt,
//             restart and a saturating retired-instruction counter.
//             Optional alignment trap enabled by defining PC_ALIGN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               CNT_WIDTH = 32
) (
    input  wire                 clk,
    input  wire                 rst_n,
    pc_fetch_ctrl_if.master     bus
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [WIDTH-1:0]     c_SEQ_STEP = WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_pc;
    logic [CNT_WIDTH-1:0] r_retired;

    logic [WIDTH-1:0]     w_offset;
    logic [WIDTH-1:0]     w_next_pc;
    logic                 w_self_branch;
    logic                 w_align_fault;
    logic [CNT_WIDTH-1:0] w_retired_inc;
    logic                 w_advance;

    // Modulo-2^WIDTH add; ImmOp arrives already sign-extended.
    assign w_offset      = bus.PCsrc ? bus.ImmOp : c_SEQ_STEP;
    assign w_next_pc     = r_pc + w_offset;
    assign w_self_branch = bus.PCsrc && (bus.ImmOp == '0);
    assign w_retired_inc = (r_retired == c_CNT_MAX) ? r_retired : r_retired + 1'b1;
    assign w_advance     = (r_state == S_RUN) && bus.en;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_align_fault = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else if (w_advance && w_align_fault) begin
            r_misaligned <= 1'b1;
        end else if ((r_state == S_HALT) && bus.restart) begin
            r_misaligned <= 1'b0;
        end
    end

    assign bus.misaligned = r_misaligned;
`else
    assign w_align_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (bus.en) begin
                        // A faulting target neither retires nor moves the PC.
                        if (w_align_fault) begin
                            r_state <= S_HALT;
                        end else begin
                            r_retired <= w_retired_inc;
                            if (w_self_branch) begin
                                r_state <= S_HALT;
                            end else begin
                                r_pc <= w_next_pc;
                            end
                        end
                    end
                end
                S_HALT: begin
                    if (bus.restart) begin
                        r_state <= S_BOOT;
                        r_pc    <= RESET_PC;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_pc    <= RESET_PC;
                end
            endcase
        end
    end

    assign bus.PC       = r_pc;
    assign bus.pc_valid = (r_state == S_RUN);
    assign bus.halted   = (r_state == S_HALT);
    assign bus.retired  = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Brief    : Directed and randomized bench for pc_fetch_ctrl against a
//             behavioural model of the fetch sequencing rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_ctrl;

    localparam int               c_WIDTH = 32;
    localparam int               c_CNTW  = 8;
    localparam logic [31:0]      c_RST   = 32'h0;
    localparam int               c_CMAX  = (1 << c_CNTW) - 1;

    logic clk;
    logic rst_n;

    pc_fetch_ctrl_if #(.WIDTH(c_WIDTH), .CNT_WIDTH(c_CNTW)) bus ();

    pc_fetch_ctrl #(
        .WIDTH     (c_WIDTH),
        .RESET_PC  (c_RST),
        .CNT_WIDTH (c_CNTW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: where the core is, not how the RTL encodes it.
    logic [31:0] m_pc;
    int          m_ret;
    bit          m_booting;
    bit          m_halted;
    bit          m_mis;

    task automatic model_reset();
        m_pc      = c_RST;
        m_ret     = 0;
        m_booting = 1'b1;
        m_halted  = 1'b0;
        m_mis     = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit ps, input logic [31:0] imm, input bit rs);
        logic [31:0] target;
        target = m_pc + (ps ? imm : 32'd4);
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            if (rs) begin
                m_halted  = 1'b0;
                m_booting = 1'b1;
                m_pc      = c_RST;
                m_mis     = 1'b0;
            end
        end else if (e) begin
`ifdef PC_ALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
                m_halted = 1'b1;
                m_mis    = 1'b1;
            end else
`endif
            begin
                if (m_ret < c_CMAX) m_ret = m_ret + 1;
                if (ps && imm == 32'd0) m_halted = 1'b1;
                else                    m_pc     = target;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PC"},       64'(bus.PC),       64'(m_pc));
        check({tag, ".pc_valid"}, 64'(bus.pc_valid), 64'(!m_booting && !m_halted));
        check({tag, ".halted"},   64'(bus.halted),   64'(m_halted));
        check({tag, ".retired"},  64'(bus.retired),  64'(m_ret));
`ifdef PC_ALIGN_CHECK_EN
        check({tag, ".misaligned"}, 64'(bus.misaligned), 64'(m_mis));
`endif
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic step(input string tag, input bit e, input bit ps, input logic [31:0] imm, input bit rs);
        bus.en      = e;
        bus.PCsrc   = ps;
        bus.ImmOp   = imm;
        bus.restart = rs;
        @(posedge clk);
        model_edge(e, ps, imm, rs);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          ret_before;
        logic [31:0] imm;
        bit          e, ps, rs;

        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.PCsrc   = 1'b0;
        bus.ImmOp   = '0;
        bus.restart = 1'b0;
        model_reset();
        #2;
        check("reset.PC", 64'(bus.PC), 64'h0);
        check("reset.pc_valid", 64'(bus.pc_valid), 64'h0);
        check("reset.retired", 64'(bus.retired), 64'h0);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot cycle ignores en; second edge fetches sequentially.
        step("boot", 1'b1, 1'b0, 32'h0, 1'b1);
        check("boot.PC", 64'(bus.PC), 64'h0);
        for (int i = 0; i < 5; i++) step("seq", 1'b1, 1'b0, 32'h0, 1'b0);
        check("seq.PC", 64'(bus.PC), 64'h14);
        check("seq.retired", 64'(bus.retired), 64'd5);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'($urandom), $urandom, 1'b0);
        check("stall.PC", 64'(bus.PC), 64'h14);
        check("stall.retired", 64'(bus.retired), 64'd5);

        // Branches: backward, forward, then across the top of the address space.
        step("br_m4", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step("br_m8", 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        check("br_neg.PC", 64'(bus.PC), 64'h08);
        step("br_fwd", 1'b1, 1'b1, 32'h100, 1'b0);
        check("br_fwd.PC", 64'(bus.PC), 64'h108);
        step("br_top", 1'b1, 1'b1, 32'hFFFF_FFFC - 32'h108, 1'b0);
        check("br_top.PC", 64'(bus.PC), 64'hFFFF_FFFC);
        step("wrap", 1'b1, 1'b0, 32'h0, 1'b0);
        check("wrap.PC", 64'(bus.PC), 64'h0);

        // restart outside HALT is a no-op.
        step("rs_run", 1'b1, 1'b0, 32'h0, 1'b1);
        check("rs_run.pc_valid", 64'(bus.pc_valid), 64'h1);

        // Branch-to-self halt, frozen state, restart keeps the count.
        step("to20", 1'b1, 1'b1, 32'h1C, 1'b0);
        ret_before = int'(bus.retired);
        step("self", 1'b1, 1'b1, 32'h0, 1'b0);
        check("halt.PC", 64'(bus.PC), 64'h20);
        check("halt.halted", 64'(bus.halted), 64'h1);
        check("halt.retired", 64'(bus.retired), 64'(ret_before + 1));
        for (int i = 0; i < 3; i++) step("frozen", 1'b1, 1'($urandom), $urandom | 32'h4, 1'b0);
        step("restart", 1'b0, 1'b0, 32'h0, 1'b1);
        check("restart.PC", 64'(bus.PC), 64'h0);
        check("restart.halted", 64'(bus.halted), 64'h0);
        check("restart.retired", 64'(bus.retired), 64'd13);

        // Asynchronous reset between edges at PC=0x40.
        step("boot2", 1'b0, 1'b0, 32'h0, 1'b0);
        step("to40", 1'b1, 1'b1, 32'h40, 1'b0);
        check("to40.PC", 64'(bus.PC), 64'h40);
        do_reset();
        check("areset.PC", 64'(bus.PC), 64'h0);
        check("areset.retired", 64'(bus.retired), 64'h0);

`ifdef PC_ALIGN_CHECK_EN
        step("boot3", 1'b1, 1'b0, 32'h0, 1'b0);
        step("to10", 1'b1, 1'b1, 32'h10, 1'b0);
        step("misal", 1'b1, 1'b1, 32'h2, 1'b0);
        check("misal.PC", 64'(bus.PC), 64'h10);
        check("misal.flag", 64'(bus.misaligned), 64'h1);
        check("misal.retired", 64'(bus.retired), 64'h1);
        step("misal_rs", 1'b1, 1'b0, 32'h0, 1'b1);
        check("misal_rs.flag", 64'(bus.misaligned), 64'h0);
`endif

        // Random traffic; long enough for the counter to saturate.
        for (int i = 0; i < 800; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            ps = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       imm = 32'h0;
                1:       imm = $urandom;
                default: imm = {$urandom_range(0, 63) - 32, 2'b00};
            endcase
            rs = ($urandom_range(0, 2) == 0);
            step("rand", e, ps, imm, rs);
        end
        check("sat.retired", 64'(m_ret), 64'(c_CMAX));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
